mux_console_responder: RTL and testbench

- Memory-mapped console port that answers CPU6 bus cycles: the responder end of the CPU's address/data bus.
- Decodes a two-byte window (status, data) and buffers CPU writes in a TX FIFO.
- Serialises FIFO bytes onto an 8N1 line.
- Holds one received byte, delivered by an upstream receiver over a valid/ready handshake, for CPU reads.

---
 rtl/mux_console_responder_if.sv | 20 ++
 rtl/mux_console_responder.sv | 185 ++++++++++++++++++
 tb/tb_mux_console_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_console_responder_if.sv
// CPU-side bus of the console responder: address, write strobe/data, read strobe
// and the registered read return.
interface mux_console_responder_if;
    logic [15:0] addressBus;
    logic [7:0]  write_data;
    logic        write_en;
    logic        read_en;
    logic [7:0]  read_data;
    logic        read_valid;

    modport master (
        output addressBus, write_data, write_en, read_en,
        input  read_data, read_valid
    );

    modport slave (
        input  addressBus, write_data, write_en, read_en,
        output read_data, read_valid
    );
endinterface

// File: rtl/mux_console_responder.sv
// Memory-mapped console: status/data byte window, TX FIFO feeding an 8N1
// serializer, and a one-byte RX holding register fed by a valid/ready handshake.
module mux_console_responder #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    mux_console_responder_if.slave  bus,
    output logic                    tx,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic                    rx_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic             hit, rdHit, statusRead, dataRead, dataWrite, flush;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count;
    logic             fifoEmpty, fifoFull, pop, push, drop;
    logic [1:0]       state;
    logic [BIT_W-1:0] bitCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             txReg, bitDone, txIdle;
    logic             rxFull, txOverrun;
    logic [7:0]       rxHold, readDataReg, statusByte;
    logic             readValidReg;

    assign hit        = bus.addressBus[15:1] == BASE_ADDR[15:1];
    assign rdHit      = bus.read_en & hit;
    assign statusRead = rdHit & ~bus.addressBus[0];
    assign dataRead   = rdHit &  bus.addressBus[0];
    assign dataWrite  = bus.write_en & hit &  bus.addressBus[0];
    assign flush      = bus.write_en & hit & ~bus.addressBus[0] & bus.write_data[7];

    assign fifoEmpty = count == '0;
    assign fifoFull  = count == CNT_W'(FIFO_DEPTH);
    assign bitDone   = bitCnt == BIT_W'(CLKS_PER_BIT - 1);
    assign txIdle    = fifoEmpty && (state == ST_IDLE);

    // The serializer takes a byte either from idle or straight out of a finished stop bit.
    assign pop  = !flush && !fifoEmpty && ((state == ST_IDLE) || (state == ST_STOP && bitDone));
    assign push = dataWrite && (!fifoFull || pop);
    assign drop = dataWrite && fifoFull && !pop;

    assign statusByte = {4'b0000, txOverrun, txIdle, ~fifoFull, rxFull};

    assign tx             = txReg;
    assign rx_ready       = ~rxFull;
    assign bus.read_data  = readDataReg;
    assign bus.read_valid = readValidReg;

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= bus.write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state    <= ST_IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    bitCnt <= '0;
                    bitIdx <= '0;
                    if (pop) begin
                        shiftReg <= fifoMem[rdPtr];
                        state    <= ST_START;
                        txReg    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bitDone) begin
                        state  <= ST_DATA;
                        bitCnt <= '0;
                        bitIdx <= '0;
                        txReg  <= shiftReg[0];
                    end else begin
                        bitCnt <= bitCnt + BIT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bitDone) begin
                        bitCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state  <= ST_STOP;
                            bitIdx <= '0;
                            txReg  <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            txReg  <= shiftReg[bitIdx + 3'd1];
                        end
                    end else begin
                        bitCnt <= bitCnt + BIT_W'(1);
                    end
                end
                default: begin
                    if (bitDone) begin
                        bitCnt <= '0;
                        bitIdx <= '0;
                        if (pop) begin
                            shiftReg <= fifoMem[rdPtr];
                            state    <= ST_START;
                            txReg    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            txReg <= 1'b1;
                        end
                    end else begin
                        bitCnt <= bitCnt + BIT_W'(1);
                    end
                end
            endcase
        end
    end

    // A status read returns the pre-clear overrun flag, since readDataReg samples it at the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            txOverrun <= 1'b0;
        end else if (drop) begin
            txOverrun <= 1'b1;
        end else if (statusRead) begin
            txOverrun <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxFull <= 1'b0;
            rxHold <= '0;
        end else begin
            if (dataRead) rxFull <= 1'b0;
            if (rx_valid && !rxFull) begin
                rxFull <= 1'b1;
                rxHold <= rx_byte;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readDataReg  <= '0;
            readValidReg <= 1'b0;
        end else begin
            readValidReg <= rdHit;
            if (rdHit) begin
                readDataReg <= bus.addressBus[0] ? rxHold : statusByte;
            end else begin
                readDataReg <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mux_console_responder.sv
// Directed and randomized checks of the console responder against a line/flag
// reference model kept in the bench.
module tb_mux_console_responder;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;

    mux_console_responder_if bus();

    mux_console_responder #(
        .BASE_ADDR   (16'hF200),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .tx      (tx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected line: frames of {stop, byte, start} sent back-to-back from lineStart, idle high otherwise.
    logic       lineOn = 1'b0;
    int         lineStart = 0;
    logic [7:0] lineBytes[$];

    function automatic logic expLine(int off);
        logic [9:0] fr;
        int f, b;
        if (off < 0 || off >= lineBytes.size() * FRAME) return 1'b1;
        f  = off / FRAME;
        b  = (off % FRAME) / CPB;
        fr = {1'b1, lineBytes[f], 1'b0};
        return fr[b];
    endfunction

    task automatic chk1(string tag, logic got, logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk8(string tag, logic [7:0] got, logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (lineOn) chk1("txLine", tx, expLine(cyc - lineStart));
    end

    task automatic idle(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cpuWrite(logic [15:0] a, logic [7:0] d);
        bus.addressBus = a;
        bus.write_data = d;
        bus.write_en   = 1'b1;
        @(negedge clock);
        bus.write_en   = 1'b0;
    endtask

    task automatic cpuRead(string tag, logic [15:0] a, logic expV, logic [7:0] expD);
        bus.addressBus = a;
        bus.read_en    = 1'b1;
        @(negedge clock);
        bus.read_en    = 1'b0;
        chk1({tag, ".valid"}, bus.read_valid, expV);
        chk8({tag, ".data"}, bus.read_data, expV ? expD : 8'h00);
        @(negedge clock);
        chk1({tag, ".validDrop"}, bus.read_valid, 1'b0);
        chk8({tag, ".dataDrop"}, bus.read_data, 8'h00);
    endtask

    logic [7:0]  b[6];
    logic [15:0] addrList[6];
    logic [15:0] addr;
    logic [7:0]  d, expD;
    logic        hitM, rxFullM;
    logic [7:0]  rxHoldM;
    int          op;

    initial begin
        bus.addressBus = 16'h0000;
        bus.write_data = 8'h00;
        bus.write_en   = 1'b0;
        bus.read_en    = 1'b0;
        addrList = '{16'hF200, 16'hF201, 16'hF202, 16'hF203, 16'hF1FE, 16'hF1FF};

        // Reset and idle
        idle(3);
        chk1("rst.tx", tx, 1'b1);
        chk1("rst.valid", bus.read_valid, 1'b0);
        chk1("rst.rxReady", rx_ready, 1'b1);
        reset = 1'b0;
        idle(50);
        chk1("idle.tx", tx, 1'b1);
        chk1("idle.valid", bus.read_valid, 1'b0);
        chk8("idle.data", bus.read_data, 8'h00);
        chk1("idle.rxReady", rx_ready, 1'b1);
        cpuRead("idle.status", 16'hF200, 1'b1, 8'h06);

        // Single frame 0xA5
        lineBytes = {8'hA5};
        lineStart = cyc + 2;
        lineOn    = 1'b1;
        cpuWrite(16'hF201, 8'hA5);
        chk1("single.noFallYet", tx, 1'b1);
        @(negedge clock);
        chk1("single.fall", tx, 1'b0);
        idle(4);
        cpuRead("single.busy", 16'hF200, 1'b1, 8'h02);
        idle(40);
        cpuRead("single.done", 16'hF200, 1'b1, 8'h06);

        // Six consecutive writes: five sent back-to-back, one dropped
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        lineBytes = {b[0], b[1], b[2], b[3], b[4]};
        lineStart = cyc + 2;
        for (int i = 0; i < 6; i++) cpuWrite(16'hF201, b[i]);
        idle(40);
        cpuRead("burst.overrun", 16'hF200, 1'b1, 8'h0A);
        cpuRead("burst.cleared", 16'hF200, 1'b1, 8'h02);
        idle(160);
        cpuRead("burst.done", 16'hF200, 1'b1, 8'h06);

        // RX handshake with a pending second byte
        rx_byte  = 8'h3C;
        rx_valid = 1'b1;
        @(negedge clock);
        chk1("rx.full", rx_ready, 1'b0);
        rx_byte = 8'h7E;
        idle(2);
        chk1("rx.held", rx_ready, 1'b0);
        bus.addressBus = 16'hF201;
        bus.read_en    = 1'b1;
        @(negedge clock);
        bus.read_en = 1'b0;
        chk1("rx.readValid", bus.read_valid, 1'b1);
        chk8("rx.readData", bus.read_data, 8'h3C);
        chk1("rx.readyAfterRead", rx_ready, 1'b1);
        @(negedge clock);
        chk1("rx.second", rx_ready, 1'b0);
        chk1("rx.validDrop", bus.read_valid, 1'b0);
        rx_valid = 1'b0;
        cpuRead("rx.status", 16'hF200, 1'b1, 8'h07);
        cpuRead("rx.data2", 16'hF201, 1'b1, 8'h7E);
        cpuRead("rx.status2", 16'hF200, 1'b1, 8'h06);

        // Accesses outside the window
        rx_byte  = 8'h55;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        cpuRead("miss.F202", 16'hF202, 1'b0, 8'h00);
        cpuRead("miss.F1FF", 16'hF1FF, 1'b0, 8'h00);
        cpuWrite(16'hF202, 8'h11);
        cpuWrite(16'hF1FF, 8'h22);
        cpuWrite(16'hF1FE, 8'h80);
        idle(3);
        chk1("miss.tx", tx, 1'b1);
        cpuRead("miss.status", 16'hF200, 1'b1, 8'h07);
        cpuRead("miss.rxData", 16'hF201, 1'b1, 8'h55);
        cpuRead("miss.status2", 16'hF200, 1'b1, 8'h06);

        // Flush mid-frame with two bytes queued
        lineOn = 1'b0;
        cpuWrite(16'hF201, 8'h00);
        cpuWrite(16'hF201, 8'($urandom));
        cpuWrite(16'hF201, 8'($urandom));
        idle(8);
        chk1("flush.midFrame", tx, 1'b0);
        cpuWrite(16'hF200, 8'h7F);
        chk1("flush.noopWrite", tx, 1'b0);
        cpuRead("flush.queued", 16'hF200, 1'b1, 8'h02);
        cpuWrite(16'hF200, 8'h80);
        chk1("flush.txHigh", tx, 1'b1);
        lineBytes = {};
        lineOn    = 1'b1;
        cpuRead("flush.status", 16'hF200, 1'b1, 8'h06);
        idle(100);
        cpuRead("flush.quiet", 16'hF200, 1'b1, 8'h06);

        // Randomized accesses against the flag/line model
        rxFullM = 1'b0;
        rxHoldM = 8'h55;
        for (int it = 0; it < 40; it++) begin
            op   = int'($urandom_range(0, 3));
            addr = addrList[$urandom_range(0, 5)];
            hitM = (addr >> 1) == (16'hF200 >> 1);
            d    = 8'($urandom);
            case (op)
                0: begin
                    expD = addr[0] ? rxHoldM : (8'h06 | {7'b0, rxFullM});
                    if (hitM && addr[0]) rxFullM = 1'b0;
                    cpuRead("rnd.read", addr, hitM, expD);
                end
                1: begin
                    if (hitM && addr[0]) begin
                        lineBytes = {d};
                        lineStart = cyc + 2;
                    end
                    cpuWrite(addr, d);
                    idle(FRAME + 3);
                end
                2: begin
                    if (!rxFullM) begin
                        rx_byte  = d;
                        rx_valid = 1'b1;
                        @(negedge clock);
                        rx_valid = 1'b0;
                        rxFullM  = 1'b1;
                        rxHoldM  = d;
                    end
                    chk1("rnd.rxReady", rx_ready, ~rxFullM);
                end
                default: begin
                    idle(int'($urandom_range(1, 5)));
                    chk1("rnd.rxReadyIdle", rx_ready, ~rxFullM);
                end
            endcase
        end

        // Reset in the middle of a frame
        lineOn = 1'b0;
        cpuWrite(16'hF201, 8'h00);
        idle(6);
        chk1("rstMid.low", tx, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk1("rstMid.high", tx, 1'b1);
        reset = 1'b0;
        lineBytes = {};
        lineOn    = 1'b1;
        idle(60);
        cpuRead("rstMid.status", 16'hF200, 1'b1, 8'h06);

        lineOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
